// File: rtl/systolic_ctrl_ws_pkg.sv
// Shared parameters for the weight-stationary systolic array: PE mode encodings,
// controller state encoding and a small index-width helper.
package systolic_ctrl_ws_pkg;

  localparam logic PEMODE_WL = 1'b0;
  localparam logic PEMODE_PS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_WLOAD   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Index width that never collapses to zero bits for a single-entry dimension.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Diagonal activation skew: row r is fed during compute steps r .. r+vec_len-1.
module systolic_skew_gen #(
  parameter int ROWS  = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 12
) (
  input  logic [CNT_W-1:0] t,
  input  logic [LEN_W-1:0] vec_len,
  output logic [ROWS-1:0]  a_row_en
);

  // Per-row window compare; counter width leaves headroom so r+vec_len never wraps.
  always_comb begin
    a_row_en = '0;
    for (int r = 0; r < ROWS; r++) begin
      if ((t >= CNT_W'(r)) && (t < (CNT_W'(r) + CNT_W'(vec_len)))) begin
        a_row_en[r] = 1'b1;
      end else begin
        a_row_en[r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl_ws.sv
// Job sequencer for a weight-stationary systolic array: clears partial sums, loads
// weights row by row, then streams skewed activations and reports completion.
module systolic_ctrl_ws
  import systolic_ctrl_ws_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        vec_len,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    pe_mode,
  output logic                    psum_clr,
  output logic                    w_req,
  output logic [idx_w(ROWS)-1:0]  w_row_idx,
  output logic [ROWS-1:0]         a_row_en,
  output logic [LEN_W-1:0]        a_vec_idx
);

  localparam int RIDX_W = idx_w(ROWS);
  localparam int CNT_W  = LEN_W + $clog2(ROWS + COLS) + 1;

  state_e              state_r, state_s;
  logic [LEN_W-1:0]    vec_len_r;
  logic [CNT_W-1:0]    t_r;
  logic [RIDX_W-1:0]   wcnt_r;
  logic [CNT_W-1:0]    t_last_s;
  logic                kill_s;
  logic [ROWS-1:0]     skew_en_s;

  logic                busy_s, done_s, pe_mode_s, psum_clr_s, w_req_s;
  logic [RIDX_W-1:0]   w_row_idx_s;
  logic [ROWS-1:0]     a_row_en_s;
  logic [LEN_W-1:0]    a_vec_idx_s;

  // Last compute step is vec_len+ROWS+COLS-3; modular add handles tiny arrays.
  assign t_last_s = CNT_W'(vec_len_r) + CNT_W'(ROWS + COLS - 3);
  assign kill_s   = abort && (state_r != ST_IDLE);

  systolic_skew_gen #(
    .ROWS  (ROWS),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_skew (
    .t        (t_r),
    .vec_len  (vec_len_r),
    .a_row_en (skew_en_s)
  );

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    if (start) state_s = ST_CLEAR; else state_s = ST_IDLE;
      ST_CLEAR:   state_s = ST_WLOAD;
      ST_WLOAD: begin
        if (wcnt_r == RIDX_W'(0)) begin
          if (vec_len_r == LEN_W'(0)) state_s = ST_DONE; else state_s = ST_COMPUTE;
        end else begin
          state_s = ST_WLOAD;
        end
      end
      ST_COMPUTE: if (t_r == t_last_s) state_s = ST_DONE; else state_s = ST_COMPUTE;
      ST_DONE:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
    if (kill_s) begin
      state_s = ST_IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // State, latched job length and step counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      vec_len_r <= '0;
      t_r       <= '0;
      wcnt_r    <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && start) vec_len_r <= vec_len;
      else                               vec_len_r <= vec_len_r;
      if (state_r == ST_COMPUTE) t_r <= t_r + CNT_W'(1);
      else                       t_r <= '0;
      if (state_r == ST_WLOAD)   wcnt_r <= wcnt_r - RIDX_W'(1);
      else                       wcnt_r <= RIDX_W'(ROWS - 1);
    end
  end

  // Control decode from the current state; registered below, so the array lags by one cycle.
  always_comb begin
    busy_s      = (state_r != ST_IDLE);
    done_s      = (state_r == ST_DONE);
    psum_clr_s  = (state_r == ST_CLEAR);
    w_req_s     = (state_r == ST_WLOAD);
    pe_mode_s   = (state_r == ST_WLOAD) ? PEMODE_WL : PEMODE_PS;
    w_row_idx_s = (state_r == ST_WLOAD) ? wcnt_r : RIDX_W'(0);
    a_row_en_s  = '0;
    a_vec_idx_s = '0;
    if (state_r == ST_COMPUTE) begin
      a_row_en_s = skew_en_s;
      if (t_r < CNT_W'(vec_len_r)) a_vec_idx_s = t_r[LEN_W-1:0];
      else                         a_vec_idx_s = '0;
    end else begin
      a_row_en_s  = '0;
      a_vec_idx_s = '0;
    end
  end

  // Output registers; reset and abort drop straight to idle values so no done escapes.
  always_ff @(posedge clk) begin
    if (reset || kill_s) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pe_mode   <= PEMODE_PS;
      psum_clr  <= 1'b0;
      w_req     <= 1'b0;
      w_row_idx <= '0;
      a_row_en  <= '0;
      a_vec_idx <= '0;
    end else begin
      busy      <= busy_s;
      done      <= done_s;
      pe_mode   <= pe_mode_s;
      psum_clr  <= psum_clr_s;
      w_req     <= w_req_s;
      w_row_idx <= w_row_idx_s;
      a_row_en  <= a_row_en_s;
      a_vec_idx <= a_vec_idx_s;
    end
  end

endmodule
